// File: rtl/sine_ctrl_pkg.sv
// Shared types and constants for the sine-burst sequencer.
package sine_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int TIMEOUT_TK_DEF = 1024;
  // Oscillator steps per full sine period at the nominal coefficient.
  localparam int NOM_PERIOD     = 402;

endpackage

// File: rtl/sine_burst_ctrl_if.sv
// Control/oscillator-side signal bundle of the sine-burst sequencer.
interface sine_burst_ctrl_if #(
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 8,
  parameter int WAVE_W = 8
) ();

  logic                     start;
  logic                     abort;
  logic [DIV_W-1:0]         div;
  logic [CNT_W-1:0]         n_periods;
  logic signed [WAVE_W-1:0] wave_in;
  logic                     osc_clr;
  logic                     osc_en;
  logic                     busy;
  logic                     done;
  logic                     err_timeout;
  logic [CNT_W-1:0]         period_cnt;

  modport master (
    output start, abort, div, n_periods, wave_in,
    input  osc_clr, osc_en, busy, done, err_timeout, period_cnt
  );

  modport slave (
    input  start, abort, div, n_periods, wave_in,
    output osc_clr, osc_en, busy, done, err_timeout, period_cnt
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divide-by-N tick generator; divider latched on load, 0 treated as 1.
module tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == div_q - DIV_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      div_q <= (div == '0) ? DIV_W'(1) : div;
      cnt   <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sine_burst_ctrl.sv
// Burst sequencer: clears the oscillator, paces its steps, counts rising zero
// crossings and stops after the requested number of periods or on timeout.
module sine_burst_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int CNT_W      = 8,
  parameter int WAVE_W     = 8,
  parameter int TIMEOUT_TK = TIMEOUT_TK_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sine_burst_ctrl_if.slave   bus
);

  localparam int STEP_W = $clog2(TIMEOUT_TK + 1);

  state_t            state;
  logic [CNT_W-1:0]  n_lat;
  logic [STEP_W-1:0] step_cnt;
  logic              step_d;
  logic              prev_neg;

  logic              accept;
  logic              presc_en;
  logic              tick;
  logic              wave_neg;
  logic              crossing;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit_n;
  logic              timeout;

  assign accept   = bus.start && !bus.abort && (state == ST_IDLE || state == ST_DONE);
  assign presc_en = (state == ST_INIT && n_lat != '0) || state == ST_RUN;
  assign wave_neg = bus.wave_in[WAVE_W-1];
  // wave_in reflects the step issued on the previous cycle, flagged by step_d.
  assign crossing = (state == ST_RUN) && step_d && prev_neg && !wave_neg;
  assign cnt_inc  = (bus.period_cnt == '1) ? bus.period_cnt : bus.period_cnt + CNT_W'(1);
  assign hit_n    = crossing && (cnt_inc == n_lat);
  // A crossing in the same cycle restarts the step window, so it beats timeout.
  assign timeout  = (state == ST_RUN) && bus.osc_en && !crossing &&
                    (step_cnt == STEP_W'(TIMEOUT_TK - 1));

  tick_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (presc_en),
    .div  (bus.div),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      n_lat           <= '0;
      step_cnt        <= '0;
      step_d          <= 1'b0;
      prev_neg        <= 1'b0;
      bus.osc_clr     <= 1'b0;
      bus.osc_en      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.period_cnt  <= '0;
    end else if (bus.abort) begin
      state       <= ST_IDLE;
      step_d      <= 1'b0;
      bus.osc_clr <= 1'b0;
      bus.osc_en  <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.osc_en <= 1'b0;
          if (bus.start) begin
            state           <= ST_INIT;
            n_lat           <= bus.n_periods;
            step_cnt        <= '0;
            step_d          <= 1'b0;
            prev_neg        <= 1'b0;
            bus.osc_clr     <= 1'b1;
            bus.busy        <= 1'b1;
            bus.done        <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.period_cnt  <= '0;
          end
        end
        ST_INIT: begin
          bus.osc_clr <= 1'b0;
          if (n_lat != '0) begin
            state      <= ST_RUN;
            bus.osc_en <= tick;
          end else begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        ST_RUN: begin
          bus.osc_en <= tick && !hit_n && !timeout;
          step_d     <= bus.osc_en;
          if (crossing) begin
            bus.period_cnt <= cnt_inc;
            prev_neg       <= 1'b0;
            step_cnt       <= '0;
          end else begin
            if (step_d)     prev_neg <= wave_neg;
            if (bus.osc_en) step_cnt <= step_cnt + STEP_W'(1);
          end
          if (hit_n || timeout) begin
            state    <= ST_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
          if (timeout) bus.err_timeout <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_burst_ctrl.sv
// Directed bench for sine_burst_ctrl with a square-ish oscillator model whose
// sign follows a 402-step period after each clear.
module tb_sine_burst_ctrl;
  import sine_ctrl_pkg::*;

  localparam int DIV_W  = 16;
  localparam int CNT_W  = 8;
  localparam int WAVE_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sine_burst_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .WAVE_W(WAVE_W)) ifc ();

  sine_burst_ctrl #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .WAVE_W(WAVE_W), .TIMEOUT_TK(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Oscillator model: after step s the sample is positive for s%402 < 201.
  int                       k = 0;
  logic signed [WAVE_W-1:0] model_wave = '0;
  logic                     force_pos = 1'b0;

  always @(posedge clk) begin
    if (ifc.osc_clr) begin
      k          <= 0;
      model_wave <= '0;
    end else if (ifc.osc_en) begin
      k          <= k + 1;
      model_wave <= (((k + 1) % NOM_PERIOD) < (NOM_PERIOD / 2)) ? 8'sd50 : -8'sd50;
    end
  end

  assign ifc.wave_in = force_pos ? 8'sh10 : model_wave;

  // Activity monitor; cycle 1 is the cycle right after the start edge.
  int cyc, en_cnt, clr_cnt, first_en, last_en, gap_bad, exp_gap;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ifc.osc_en) begin
      if (en_cnt == 0) first_en = cyc;
      else if (cyc - last_en != exp_gap) gap_bad = gap_bad + 1;
      last_en = cyc;
      en_cnt  = en_cnt + 1;
    end
    if (ifc.osc_clr) clr_cnt = clr_cnt + 1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present start for one edge; returns sampled in cycle 1.
  task automatic kick(input logic [DIV_W-1:0] d, input logic [CNT_W-1:0] n, input int gap);
    ifc.start     = 1'b1;
    ifc.div       = d;
    ifc.n_periods = n;
    cyc = 0; en_cnt = 0; clr_cnt = 0; first_en = 0; last_en = 0; gap_bad = 0;
    exp_gap = gap;
    step();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ifc.done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.abort = 1'b0; ifc.div = '0; ifc.n_periods = '0;
    rst = 1'b0;
    step_n(3);
    checks++;
    if ({ifc.osc_en, ifc.osc_clr, ifc.busy, ifc.done, ifc.err_timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {ifc.osc_en, ifc.osc_clr, ifc.busy, ifc.done, ifc.err_timeout});
    end
    checks++;
    if (ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_period_cnt: got %0d want 0", ifc.period_cnt);
    end
    rst = 1'b1;
    step_n(2);
  endtask

  task automatic test_run_div1();
    bit ok;
    kick(16'd1, 8'd2, 1);
    checks++;
    if ({ifc.osc_clr, ifc.busy, ifc.osc_en} !== 3'b110) begin
      errors++; $display("FAIL div1_init: clr/busy/en got %b want 110",
                         {ifc.osc_clr, ifc.busy, ifc.osc_en});
    end
    step();
    checks++;
    if ({ifc.osc_clr, ifc.osc_en} !== 2'b01) begin
      errors++; $display("FAIL div1_first_step: clr/en got %b want 01", {ifc.osc_clr, ifc.osc_en});
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div1_done_wait: done not seen within 2000 cycles"); end
    checks++;
    if (ifc.period_cnt !== 8'd2) begin
      errors++; $display("FAIL div1_period_cnt: got %0d want 2", ifc.period_cnt);
    end
    checks++;
    if ({ifc.err_timeout, ifc.busy} !== 2'b00) begin
      errors++; $display("FAIL div1_err_busy: got %b want 00", {ifc.err_timeout, ifc.busy});
    end
    // 804 steps to the second crossing plus the one issued while it was sampled.
    checks++;
    if (en_cnt != 805) begin errors++; $display("FAIL div1_steps: got %0d want 805", en_cnt); end
    checks++;
    if (clr_cnt != 1 || gap_bad != 0) begin
      errors++; $display("FAIL div1_clr_gap: clr %0d gaps %0d want 1 0", clr_cnt, gap_bad);
    end
    step_n(10);
    checks++;
    if (en_cnt != 805 || ifc.done !== 1'b1) begin
      errors++; $display("FAIL div1_quiet_after_done: steps %0d done %b want 805 1", en_cnt, ifc.done);
    end
  endtask

  task automatic test_div4();
    bit ok;
    kick(16'd4, 8'd1, 4);
    step_n(100);
    // A start while busy must be ignored.
    ifc.start = 1'b1; ifc.div = 16'd2; ifc.n_periods = 8'd7;
    step();
    ifc.start = 1'b0;
    wait_done(2500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div4_done_wait: done not seen within 2500 cycles"); end
    checks++;
    if (first_en != 5) begin errors++; $display("FAIL div4_first_step: cycle %0d want 5", first_en); end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL div4_cadence: %0d bad gaps want 0", gap_bad); end
    checks++;
    if (en_cnt != 402) begin errors++; $display("FAIL div4_steps: got %0d want 402", en_cnt); end
    checks++;
    if (ifc.period_cnt !== 8'd1 || clr_cnt != 1) begin
      errors++; $display("FAIL div4_cnt_clr: cnt %0d clr %0d want 1 1", ifc.period_cnt, clr_cnt);
    end
  endtask

  task automatic test_zero_periods();
    kick(16'd3, 8'd0, 1);
    checks++;
    if ({ifc.osc_clr, ifc.busy, ifc.done} !== 3'b110 || ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL zero_init: clr/busy/done %b cnt %0d want 110 0",
                         {ifc.osc_clr, ifc.busy, ifc.done}, ifc.period_cnt);
    end
    step();
    checks++;
    if ({ifc.osc_clr, ifc.busy, ifc.done} !== 3'b001) begin
      errors++; $display("FAIL zero_done: clr/busy/done %b want 001", {ifc.osc_clr, ifc.busy, ifc.done});
    end
    step_n(10);
    checks++;
    if (en_cnt != 0 || ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL zero_no_steps: steps %0d cnt %0d want 0 0", en_cnt, ifc.period_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    force_pos = 1'b1;
    kick(16'd1, 8'd3, 1);
    wait_done(1500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_done_wait: done not seen within 1500 cycles"); end
    checks++;
    if (ifc.err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got %b want 1", ifc.err_timeout);
    end
    checks++;
    if (en_cnt != 1024 || ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL timeout_steps: steps %0d cnt %0d want 1024 0", en_cnt, ifc.period_cnt);
    end
    force_pos = 1'b0;
  endtask

  task automatic test_back_to_back();
    kick(16'd2, 8'd0, 1);
    checks++;
    if ({ifc.err_timeout, ifc.done, ifc.busy} !== 3'b001) begin
      errors++; $display("FAIL b2b_restart: err/done/busy %b want 001",
                         {ifc.err_timeout, ifc.done, ifc.busy});
    end
    step();
    checks++;
    if (ifc.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", ifc.done); end
  endtask

  task automatic test_abort();
    bit ok;
    int clr_before;
    kick(16'd1, 8'd2, 1);
    step_n(50);
    ifc.abort = 1'b1; ifc.start = 1'b1;
    step();
    ifc.abort = 1'b0; ifc.start = 1'b0;
    checks++;
    if ({ifc.busy, ifc.done, ifc.osc_en, ifc.osc_clr} !== 4'b0000 || ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL abort_idle: busy/done/en/clr %b cnt %0d want 0000 0",
                         {ifc.busy, ifc.done, ifc.osc_en, ifc.osc_clr}, ifc.period_cnt);
    end
    clr_before = clr_cnt;
    step_n(3);
    checks++;
    if (ifc.busy !== 1'b0 || clr_cnt != clr_before) begin
      errors++; $display("FAIL abort_start_dropped: busy %b clr %0d want 0 %0d",
                         ifc.busy, clr_cnt, clr_before);
    end
    kick(16'd1, 8'd1, 1);
    checks++;
    if (ifc.period_cnt !== 8'd0 || ifc.osc_clr !== 1'b1) begin
      errors++; $display("FAIL abort_rerun_init: cnt %0d clr %b want 0 1", ifc.period_cnt, ifc.osc_clr);
    end
    wait_done(1000, ok);
    checks++;
    if (!ok || ifc.period_cnt !== 8'd1 || en_cnt != 403 || ifc.err_timeout !== 1'b0) begin
      errors++; $display("FAIL abort_rerun: ok %b cnt %0d steps %0d err %b want 1 1 403 0",
                         ok, ifc.period_cnt, en_cnt, ifc.err_timeout);
    end
  endtask

  task automatic test_reset_mid_run();
    kick(16'd1, 8'd2, 1);
    step_n(20);
    rst = 1'b0;
    #1;
    checks++;
    if ({ifc.osc_en, ifc.osc_clr, ifc.busy, ifc.done, ifc.err_timeout} !== 5'b0 ||
        ifc.period_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_mid_run: flags %b cnt %0d want 00000 0",
                         {ifc.osc_en, ifc.osc_clr, ifc.busy, ifc.done, ifc.err_timeout},
                         ifc.period_cnt);
    end
    step_n(3);
    rst = 1'b1;
    step_n(3);
    checks++;
    if ({ifc.osc_en, ifc.busy, ifc.done} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle: en/busy/done %b want 000",
                         {ifc.osc_en, ifc.busy, ifc.done});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; en_cnt = 0; clr_cnt = 0; first_en = 0; last_en = 0; gap_bad = 0; exp_gap = 1;
    test_reset();
    test_run_div1();
    test_div4();
    test_zero_periods();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
